// File: rtl/conv_maxpool_if.sv
// Stream interface between the convolutor output and the 2x2 max-pooling stage.
// The master drives samples and frame control; the slave returns pooled results.
interface conv_maxpool_if #(
  parameter int DATA_WIDTH = 16
);
  logic                         clear_i;
  logic signed [DATA_WIDTH-1:0] data_i;
  logic                         valid_i;
  logic signed [DATA_WIDTH-1:0] data_o;
  logic                         valid_o;
  logic                         done_o;
  logic                         busy_o;

  modport master (
    output clear_i, data_i, valid_i,
    input  data_o, valid_o, done_o, busy_o
  );

  modport slave (
    input  clear_i, data_i, valid_i,
    output data_o, valid_o, done_o, busy_o
  );
endinterface

// File: rtl/conv_maxpool.sv
// Streaming 2x2 stride-2 signed max-pool over a row-major IN_W x IN_H frame.
// One line of partial maxima (OUT_W registers) plus a single hold register.
// Optional build macro MAXPOOL_RELU_EN clamps negative pooled results to 0.
module conv_maxpool #(
  parameter int DATA_WIDTH = 16,
  parameter int Q          = 5,
  parameter int IN_W       = 2,
  parameter int IN_H       = 2
) (
  input logic           clk,
  input logic           rst,
  conv_maxpool_if.slave bus
);

  localparam int OUT_W  = IN_W / 2;
  localparam int COL_W  = $clog2(IN_W);
  localparam int ROW_W  = $clog2(IN_H);
  localparam int LIDX_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam bit ODD_W  = (IN_W % 2) == 1;
  localparam bit ODD_H  = (IN_H % 2) == 1;

  // Q only documents the fixed-point format; max is format-independent.
  if (IN_W < 2 || IN_H < 2 || Q >= DATA_WIDTH) begin : g_bad_params
    $error("conv_maxpool: IN_W and IN_H must be >= 2 and Q < DATA_WIDTH");
  end

  typedef logic signed [DATA_WIDTH-1:0] sample_t;

  function automatic sample_t smax(input sample_t a, input sample_t b);
    return (a > b) ? a : b;
  endfunction

  function automatic sample_t out_fn(input sample_t v);
`ifdef MAXPOOL_RELU_EN
    return v[DATA_WIDTH-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  sample_t          hold_q, hold_d;
  sample_t          data_q, data_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  sample_t          line_q [OUT_W];
  logic             line_we;
  sample_t          line_wd;
  logic [LIDX_W-1:0] lidx;
  sample_t          line_rd;

  logic accept;
  logic col_last, row_last;
  logic in_pool;

  assign accept   = bus.valid_i && !bus.clear_i;
  assign col_last = (col_q == COL_W'(IN_W - 1));
  assign row_last = (row_q == ROW_W'(IN_H - 1));
  // Trailing odd column/row are counted but never contribute to a window.
  assign in_pool  = !(ODD_W && col_last) && !(ODD_H && row_last);
  assign lidx     = LIDX_W'(col_q >> 1);
  assign line_rd  = line_q[lidx];

  // Next-state: frame position, partial maxima and registered outputs.
  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    hold_d  = hold_q;
    data_d  = data_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    busy_d  = busy_q;
    line_we = 1'b0;
    line_wd = hold_q;

    if (bus.clear_i) begin
      col_d  = '0;
      row_d  = '0;
      busy_d = 1'b0;
    end else if (accept) begin
      busy_d = 1'b1;
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
      // Frame ends on the last input sample, pooled or not.
      done_d = col_last && row_last;

      if (in_pool) begin
        unique case ({row_q[0], col_q[0]})
          2'b00: hold_d = bus.data_i;
          2'b01: begin
            line_we = 1'b1;
            line_wd = smax(hold_q, bus.data_i);
          end
          2'b10: hold_d = smax(line_rd, bus.data_i);
          2'b11: begin
            data_d  = out_fn(smax(hold_q, bus.data_i));
            valid_d = 1'b1;
          end
          default: ;
        endcase
      end
    end else if (done_q) begin
      busy_d = 1'b0;
    end
  end

  // Control and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q   <= '0;
      row_q   <= '0;
      hold_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      hold_q  <= hold_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  // Line of partial column-pair maxima; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (line_we) begin
      line_q[lidx] <= line_wd;
    end
  end

  assign bus.data_o  = data_q;
  assign bus.valid_o = valid_q;
  assign bus.done_o  = done_q;
  assign bus.busy_o  = busy_q;

endmodule

// File: tb/tb_conv_maxpool.sv
// Scoreboard bench for conv_maxpool: three instances (2x2, 4x4, 3x3 frames).
// Expected windows come from a full-image reference, not a line buffer.
module tb_conv_maxpool;

  typedef struct {
    int          dut;
    int          cyc;
    bit          v;
    logic [15:0] d;
    bit          dn;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  exp_t exp_q[$];

  logic        valid_in [3];
  logic        clear_in [3];
  logic [15:0] din;

  logic        v_o  [3];
  logic        dn_o [3];
  logic        by_o [3];
  logic [15:0] d_o  [3];

  int img   [3][4][4];
  int pos_r [3];
  int pos_c [3];
  int dim_w [3];
  int dim_h [3];

  conv_maxpool_if #(.DATA_WIDTH(16)) bus0 ();
  conv_maxpool_if #(.DATA_WIDTH(16)) bus1 ();
  conv_maxpool_if #(.DATA_WIDTH(16)) bus2 ();

  conv_maxpool #(.DATA_WIDTH(16), .Q(5), .IN_W(2), .IN_H(2)) u_dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );
  conv_maxpool #(.DATA_WIDTH(16), .Q(5), .IN_W(4), .IN_H(4)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );
  conv_maxpool #(.DATA_WIDTH(16), .Q(5), .IN_W(3), .IN_H(3)) u_dut2 (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  assign bus0.data_i = din;  assign bus1.data_i = din;  assign bus2.data_i = din;
  assign bus0.valid_i = valid_in[0];
  assign bus1.valid_i = valid_in[1];
  assign bus2.valid_i = valid_in[2];
  assign bus0.clear_i = clear_in[0];
  assign bus1.clear_i = clear_in[1];
  assign bus2.clear_i = clear_in[2];
  assign v_o[0] = bus0.valid_o;  assign dn_o[0] = bus0.done_o;
  assign v_o[1] = bus1.valid_o;  assign dn_o[1] = bus1.done_o;
  assign v_o[2] = bus2.valid_o;  assign dn_o[2] = bus2.done_o;
  assign by_o[0] = bus0.busy_o;  assign d_o[0] = bus0.data_o;
  assign by_o[1] = bus1.busy_o;  assign d_o[1] = bus1.data_o;
  assign by_o[2] = bus2.busy_o;  assign d_o[2] = bus2.data_o;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Reference: push an expected output when the bottom-right sample or last sample is driven.
  task automatic model(input int d, input int val);
    int   r, c, m;
    exp_t e;
    bit   win, last;
    r = pos_r[d];
    c = pos_c[d];
    img[d][r][c] = val;
    win  = (r % 2 == 1) && (c % 2 == 1);
    last = (r == dim_h[d] - 1) && (c == dim_w[d] - 1);
    if (win || last) begin
      e.dut = d;
      e.cyc = cyc;
      e.v   = win;
      e.dn  = last;
      e.d   = '0;
      if (win) begin
        m = imax(imax(img[d][r-1][c-1], img[d][r-1][c]), imax(img[d][r][c-1], img[d][r][c]));
`ifdef MAXPOOL_RELU_EN
        if (m < 0) m = 0;
`endif
        e.d = 16'(m);
      end
      exp_q.push_back(e);
    end
    if (c == dim_w[d] - 1) begin
      pos_c[d] = 0;
      pos_r[d] = last ? 0 : r + 1;
    end else begin
      pos_c[d] = c + 1;
    end
  endtask

  task automatic send(input int d, input int val);
    logic [31:0] v32;
    v32 = val;
    din = v32[15:0];
    valid_in[d] = 1'b1;
    @(posedge clk);
    #1;
    valid_in[d] = 1'b0;
    model(d, val);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_dut(input int d);
    din = 16'd500;
    valid_in[d] = 1'b1;
    clear_in[d] = 1'b1;
    @(posedge clk);
    #1;
    valid_in[d] = 1'b0;
    clear_in[d] = 1'b0;
    pos_r[d] = 0;
    pos_c[d] = 0;
  endtask

  // Monitor: every output strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      for (int d = 0; d < 3; d++) begin
        if (v_o[d] || dn_o[d]) begin
          if (exp_q.size() == 0) begin
            check("spurious_out", {30'd0, v_o[d], dn_o[d]}, 32'd0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("out_dut", d, e.dut);
            check("out_cycle", cyc, e.cyc);
            check("out_valid", {31'd0, v_o[d]}, {31'd0, e.v});
            check("out_done", {31'd0, dn_o[d]}, {31'd0, e.dn});
            if (e.v) check("out_data", {16'd0, d_o[d]}, {16'd0, e.d});
          end
        end
      end
    end
  end

  initial begin
    for (int d = 0; d < 3; d++) begin
      valid_in[d] = 1'b0;
      clear_in[d] = 1'b0;
      pos_r[d] = 0;
      pos_c[d] = 0;
    end
    dim_w[0] = 2; dim_h[0] = 2;
    dim_w[1] = 4; dim_h[1] = 4;
    dim_w[2] = 3; dim_h[2] = 3;
    din = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      check("rst_valid", {31'd0, v_o[d]}, 32'd0);
      check("rst_done", {31'd0, dn_o[d]}, 32'd0);
      check("rst_busy", {31'd0, by_o[d]}, 32'd0);
      check("rst_data", {16'd0, d_o[d]}, 32'd0);
    end
    rst = 1'b1;
    idle(2);

    // Basic 2x2 window, then busy drops the cycle after done
    send(0, 10); send(0, -3); send(0, 7); send(0, 25);
    @(negedge clk);
    check("busy_at_done", {31'd0, by_o[0]}, 32'd1);
    @(negedge clk);
    check("busy_after_done", {31'd0, by_o[0]}, 32'd0);
    idle(1);

    // All-negative window
    send(0, -40); send(0, -8); send(0, -100); send(0, -9);
    idle(2);

    // 4x4 frame with 2-cycle gaps after each row
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) send(1, r * 4 + c);
      idle(2);
    end

    // 3x3 frame: trailing column and row never pooled, done alone at the end
    for (int i = 1; i <= 9; i++) send(2, i);
    idle(3);

    // Clear after two samples discards them
    send(0, 100); send(0, 99);
    clear_dut(0);
    send(0, 1); send(0, 2); send(0, 3); send(0, 4);
    idle(2);

    // Asynchronous reset mid-frame
    send(0, 50); send(0, 60); send(0, 70);
    check("busy_mid_frame", {31'd0, by_o[0]}, 32'd1);
    #1 rst = 1'b0;
    #1;
    check("arst_valid", {31'd0, v_o[0]}, 32'd0);
    check("arst_done", {31'd0, dn_o[0]}, 32'd0);
    check("arst_busy", {31'd0, by_o[0]}, 32'd0);
    check("arst_data", {16'd0, d_o[0]}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      pos_r[d] = 0;
      pos_c[d] = 0;
    end
    idle(1);

    // Two back-to-back frames with no gap
    send(0, 3); send(0, -1); send(0, 2); send(0, 9);
    send(0, -5); send(0, -6); send(0, -7); send(0, -20);
    idle(3);

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_maxpool.md
Name: conv_maxpool

Overview:
- Streaming 2x2 stride-2 max-pooling stage directly downstream of the convolution top.
- Consumes the convolutor's row-major output stream (data + valid strobe, with gaps between rows) and emits one pooled value per 2x2 window.
- Holds one line of partial maxima; no backpressure, so it accepts a sample on every cycle valid_i is high.
- Tracks frame position internally and pulses done_o on the final pooled output of each frame.

Parameters:
- DATA_WIDTH, 16, sample width; signed two's-complement fixed point.
- Q, 5, fractional bits; informational only, since max is format-independent.
- IN_W, 2, input row width (N-K_SIZE+1 of the convolutor); must be >= 2.
- IN_H, 2, input rows per frame; must be >= 2.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous reset, active-low (0 = reset).
- clear_i  input  1  synchronous frame restart; discards partial state.
- data_i  input  DATA_WIDTH  convolution result sample.
- valid_i  input  1  data_i is valid this cycle.
- data_o  output  DATA_WIDTH  pooled maximum.
- valid_o  output  1  data_o is valid this cycle (single-cycle strobe per window).
- done_o  output  1  one-cycle pulse coincident with the last valid_o of a frame.
- busy_o  output  1  high from the first accepted sample until done_o, inclusive.

Behaviour:
- Reset (rst=0, async): data_o=0, valid_o=0, done_o=0, busy_o=0; col/row counters=0; line buffer contents are don't-care.
- Counters:
  - col (0..IN_W-1) and row (0..IN_H-1) advance only on valid_i.
  - col wraps to 0 at IN_W-1 and row increments.
  - When row=IN_H-1 and col=IN_W-1, both wrap to 0 and the frame is complete.
- Pooled area is OUT_W=floor(IN_W/2) by OUT_H=floor(IN_H/2).
  - Odd trailing column (col=IN_W-1 with IN_W odd) and odd trailing row (row=IN_H-1 with IN_H odd) are counted but never pooled and never produce output.
- Even row (row[0]=0), pooled region:
  - col even: hold_r <= data_i.
  - col odd: line[col>>1] <= signed max(hold_r, data_i).
- Odd row, pooled region:
  - col even: hold_r <= signed max(line[col>>1], data_i).
  - col odd: data_o <= signed max(hold_r, data_i); valid_o <= 1.
- Compare is signed on DATA_WIDTH bits. Ties select either operand; the value is identical.
- Latency: valid_o asserts exactly 1 cycle after the valid_i carrying the bottom-right sample of a window. Registered output; data_o holds its value while valid_o=0.
- valid_o and done_o deassert on any cycle without a new window completion. Gaps in valid_i are tolerated indefinitely with state held.
- done_o:
  - Asserts with the valid_o for window (OUT_H-1, OUT_W-1).
  - If trailing odd rows or columns exist, done_o instead asserts 1 cycle after the final input sample of the frame; valid_o=0 on that cycle unless a window also completes then.
  - busy_o drops on the cycle after done_o.
- Back-to-back frames: a valid_i on the cycle after the final input is treated as row 0, col 0 of the next frame; no dead cycle required.
- clear_i=1 (sync):
  - Counters -> 0; valid_o, done_o, busy_o -> 0 next cycle.
  - valid_i in the same cycle is ignored.
  - clear_i has priority over valid_i.
- Reset mid-frame: all partial windows are discarded; the next valid_i after release is row 0, col 0.
- Line buffer depth is OUT_W entries, implemented as a register array (no RAM macro).

Optional Feature:
- MAXPOOL_RELU_EN
  - Defined: output value is max(pooled, 0); any result with the sign bit set is replaced by 0 before registering data_o. Latency unchanged.
  - Undefined: raw signed maximum is output, negative values pass through.

Test Plan:
- Default params; stream 10, -3, 7, 25 (Q5 raw, row-major 2x2), valid every cycle -> one valid_o with data_o=25 one cycle after the 4th sample; done_o=1 same cycle; busy_o=0 next cycle.
- Default params; stream -40, -8, -100, -9 -> data_o=-8 (0xFFF8) without MAXPOOL_RELU_EN; data_o=0 with it defined.
- IN_W=4, IN_H=4; stream values 0..15 row-major, with 2-cycle valid_i gaps after each row -> valid_o pulses data 5, 7, 13, 15 in order; done_o only with 15.
- IN_W=3, IN_H=3; stream 1..9 -> single valid_o data_o=5 after sample 5; no output for samples 3, 6, 7, 8; done_o alone 1 cycle after sample 9.
- Default params; after 2 samples assert clear_i for 1 cycle, then stream 1, 2, 3, 4 -> data_o=4, with no output derived from the pre-clear samples.
- Default params; pull rst low after 3 samples mid-frame -> all outputs 0 immediately (asynchronous); after release stream 2 full frames back-to-back (8 samples, no gap) -> 2 correct outputs and 2 done_o pulses.
